// File: rtl/operand_pkg.sv
// Operand-select codes, SPARC V8 field constants, decoded packet type and field decode.
// Latency: none (types, constants and a pure combinational function).
// Backpressure: not applicable.
package operand_pkg;

    localparam logic [3:0] IS_SETHI   = 4'b0000;
    localparam logic [3:0] IS_BRANCH  = 4'b0100;
    localparam logic [3:0] IS_CALL    = 4'b0110;
    localparam logic [3:0] IS_ALU_R   = 4'b1000;
    localparam logic [3:0] IS_ALU_I   = 4'b1001;
    localparam logic [3:0] IS_SHIFT_R = 4'b1010;
    localparam logic [3:0] IS_SHIFT_I = 4'b1011;
    localparam logic [3:0] IS_MEM_R   = 4'b1100;
    localparam logic [3:0] IS_MEM_I   = 4'b1101;
    localparam logic [3:0] IS_JMPL_R  = 4'b1110;
    localparam logic [3:0] IS_JMPL_I  = 4'b1111;

    localparam logic [1:0] OP_FMT2  = 2'b00;
    localparam logic [1:0] OP_CALL  = 2'b01;
    localparam logic [1:0] OP_ARITH = 2'b10;
    localparam logic [1:0] OP_MEM   = 2'b11;

    localparam logic [2:0] OP2_SETHI = 3'b100;
    localparam logic [2:0] OP2_BICC  = 3'b010;

    localparam logic [5:0] OP3_SLL  = 6'b100101;
    localparam logic [5:0] OP3_SRL  = 6'b100110;
    localparam logic [5:0] OP3_SRA  = 6'b100111;
    localparam logic [5:0] OP3_JMPL = 6'b111000;

    typedef struct packed {
        logic [3:0]  is_sel;
        logic [21:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } operand_pkt_t;

    localparam int PKT_W = $bits(operand_pkt_t);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

    function automatic operand_pkt_t decode_operands(input logic [31:0] instr);
        operand_pkt_t pkt;
        logic [1:0]   op;
        logic [2:0]   op2;
        logic [5:0]   op3;
        logic         i_bit;
        op      = instr[31:30];
        op2     = instr[24:22];
        op3     = instr[24:19];
        i_bit   = instr[13];
        pkt     = '0;
        pkt.rd  = instr[29:25];
        pkt.rs1 = instr[18:14];
        pkt.rs2 = instr[4:0];
        // Format-3 immediate: simm13 sign-extended so imm[21] carries the sign.
        pkt.imm = {{9{instr[12]}}, instr[12:0]};
        case (op)
            OP_FMT2: begin
                pkt.rs1 = '0;
                pkt.rs2 = '0;
                if (op2 == OP2_SETHI) begin
                    pkt.is_sel = IS_SETHI;
                    pkt.imm    = instr[21:0];
                end else if (op2 == OP2_BICC) begin
                    pkt.is_sel = IS_BRANCH;
                    pkt.imm    = instr[21:0];
                end else begin
                    pkt.is_sel  = IS_SETHI;
                    pkt.imm     = '0;
                    pkt.illegal = 1'b1;
                end
            end
            OP_CALL: begin
                pkt.is_sel = IS_CALL;
                pkt.imm    = instr[21:0];
            end
            OP_ARITH: begin
                if (op3 == OP3_SLL || op3 == OP3_SRL || op3 == OP3_SRA)
                    pkt.is_sel = i_bit ? IS_SHIFT_I : IS_SHIFT_R;
                else if (op3 == OP3_JMPL)
                    pkt.is_sel = i_bit ? IS_JMPL_I : IS_JMPL_R;
                else
                    pkt.is_sel = i_bit ? IS_ALU_I : IS_ALU_R;
            end
            default: begin
                pkt.is_sel = i_bit ? IS_MEM_I : IS_MEM_R;
            end
        endcase
        return pkt;
    endfunction

endpackage

// File: rtl/decode_skid_buffer.sv
// Two-entry skid buffer between decode and the operand2 handler stage.
// Latency: 1 cycle from accept to out_vld when empty or draining.
// Backpressure: registered in_rdy, low only when both entries are occupied.
module decode_skid_buffer
    import operand_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy
);

    occ_state_t   state_q, state_d;
    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    logic         in_rdy_q, in_rdy_d;
    logic         accept;
    logic         drain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= OCC_EMPTY;
            ent0_q   <= '0;
            ent1_q   <= '0;
            in_rdy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            in_rdy_q <= in_rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        accept  = in_vld && in_rdy_q && !flush;
        drain   = (state_q != OCC_EMPTY) && out_rdy && !flush;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        ent0_d  = in_dat;
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && drain) begin
                        ent0_d = in_dat;
                    end else if (accept) begin
                        ent1_d  = in_dat;
                        state_d = OCC_FULL;
                    end else if (drain) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (drain) begin
                        ent0_d  = ent1_q;
                        state_d = OCC_ONE;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
        // Ready is registered from the next occupancy, so it never depends on out_rdy combinationally.
        in_rdy_d = (state_d != OCC_FULL);
    end

    assign in_rdy  = in_rdy_q;
    assign out_vld = (state_q != OCC_EMPTY);
    assign out_dat = ent0_q;

endmodule

// File: rtl/operand_source_decoder.sv
// Decodes SPARC V8 words into operand-select packets for the operand2 handler.
// Latency: 1 cycle through the skid buffer; backpressure via registered in_ready.
// Backpressure: in_ready drops only when two packets are waiting on out_ready.
module operand_source_decoder
    import operand_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_is,
    output logic [21:0] out_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    operand_pkt_t dec_pkt;
    operand_pkt_t out_pkt;
    logic [PKT_W-1:0] buf_out_dat;

    always_comb begin
        dec_pkt = decode_operands(in_instr);
    end

    decode_skid_buffer #(
        .W (PKT_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .in_vld  (in_valid),
        .in_dat  (dec_pkt),
        .in_rdy  (in_ready),
        .out_vld (out_valid),
        .out_dat (buf_out_dat),
        .out_rdy (out_ready)
    );

    assign out_pkt     = operand_pkt_t'(buf_out_dat);
    assign out_is      = out_pkt.is_sel;
    assign out_imm     = out_pkt.imm;
    assign out_rs1     = out_pkt.rs1;
    assign out_rs2     = out_pkt.rs2;
    assign out_rd      = out_pkt.rd;
    assign out_illegal = out_pkt.illegal;

endmodule

// File: tb/tb_operand_source_decoder.sv
// Directed bench for operand_source_decoder with a queue-based scoreboard.
// Inputs change 1 time unit after posedge; outputs and handshakes are sampled on negedge.
module tb_operand_source_decoder;

    typedef struct packed {
        logic [3:0]  is_sel;
        logic [21:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_is;
    logic [21:0] out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_illegal;

    int compared = 0;
    int mismatched = 0;
    int delivered = 0;
    exp_t sb[$];
    exp_t held;

    operand_source_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_is      (out_is),
        .out_imm     (out_imm),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t obs_pkt();
        exp_t o;
        o = {out_is, out_imm, out_rs1, out_rs2, out_rd, out_illegal};
        return o;
    endfunction

    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        logic [5:0] op3;
        e    = '0;
        e.rd = w[29:25];
        op3  = w[24:19];
        case (w[31:30])
            2'b00: begin
                if (w[24:22] == 3'b100) begin
                    e.imm = w[21:0];
                end else if (w[24:22] == 3'b010) begin
                    e.is_sel = 4'h4;
                    e.imm    = w[21:0];
                end else begin
                    e.ill = 1'b1;
                end
            end
            2'b01: begin
                e.is_sel = 4'h6;
                e.imm    = w[21:0];
                e.rs1    = w[18:14];
                e.rs2    = w[4:0];
            end
            default: begin
                e.rs1 = w[18:14];
                e.rs2 = w[4:0];
                e.imm = w[12] ? {9'h1FF, w[12:0]} : {9'h000, w[12:0]};
                if (w[31:30] == 2'b11)                         e.is_sel = w[13] ? 4'hD : 4'hC;
                else if (op3 >= 6'h25 && op3 <= 6'h27)         e.is_sel = w[13] ? 4'hB : 4'hA;
                else if (op3 == 6'h38)                         e.is_sel = w[13] ? 4'hF : 4'hE;
                else                                           e.is_sel = w[13] ? 4'h9 : 4'h8;
            end
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accepted input, pop and compare on each output transfer.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_nonempty_on_output", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    check("sb_packet", 64'(obs_pkt()), 64'(sb.pop_front()));
                    delivered++;
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_instr));
        end
    end

    // Called just after a posedge; returns just after the edge that accepted w.
    task automatic send(input logic [31:0] w);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_instr = w;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", 64'(n < 50), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] stream_w;
        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_outputs", 64'(obs_pkt()), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_before_first_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("in_ready_after_first_edge", 64'(in_ready), 64'd1);

        // SETHI with exact 1-cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h03048D15;
        @(negedge clk);
        check("sethi_not_early", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("sethi_latency", 64'(out_valid), 64'd1);
        check("sethi_is", 64'(out_is), 64'h0);
        check("sethi_imm", 64'(out_imm), 64'h048D15);
        check("sethi_rd", 64'(out_rd), 64'd1);
        @(posedge clk);
        #1;

        // add %g1,-1,%g2 and sra %g1,%g2,%g3
        send(32'h84007FFF);
        @(negedge clk);
        check("add_is", 64'(out_is), 64'h9);
        check("add_imm", 64'(out_imm), 64'h3FFFFF);
        check("add_rs1", 64'(out_rs1), 64'd1);
        check("add_rd", 64'(out_rd), 64'd2);
        @(posedge clk);
        #1;
        send(32'h87384002);
        @(negedge clk);
        check("sra_is", 64'(out_is), 64'hA);
        check("sra_rs2", 64'(out_rs2), 64'd2);
        @(posedge clk);
        #1;

        // Remaining formats: Bicc, CALL, JMPL imm, load reg, SLL imm, store imm negative
        send(32'h12800010);
        send(32'h7FFFFFFF);
        send(32'h81C7E008);
        send(32'hC2006004 & 32'hFFFFDFFF);
        send(32'h93286003);
        send(32'hC2207FFC);
        wait_drain("formats_drained");

        // UNIMP: illegal but still delivered
        send(32'h00000000);
        @(negedge clk);
        check("unimp_illegal", 64'(out_illegal), 64'd1);
        check("unimp_is", 64'(out_is), 64'h0);
        check("unimp_imm", 64'(out_imm), 64'h0);
        @(posedge clk);
        #1;

        // Backpressure: three issued, two held, third waits
        out_ready = 1'b0;
        send(32'h84007FFF);
        send(32'h87384002);
        in_valid = 1'b1;
        in_instr = 32'h03048D15;
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        held = obs_pkt();
        check("bp_head", 64'(held), 64'(model(32'h84007FFF)));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_stable", 64'(obs_pkt()), 64'(held));
        check("bp_valid_held", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_valid0", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_drain_valid1", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_drain_valid2", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        wait_drain("bp_drained");

        // Steady state ONE: simultaneous accept and drain for 10 cycles
        delivered = 0;
        send(32'h82006001);
        for (int k = 0; k < 10; k++) begin
            stream_w = 32'h82006000 | 32'(k + 2);
            in_valid = 1'b1;
            in_instr = stream_w;
            @(negedge clk);
            check("one_in_ready", 64'(in_ready), 64'd1);
            check("one_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_drain("one_drained");
        check("one_delivered", 64'(delivered), 64'd11);

        // Flush with buffer full and a same-cycle input
        out_ready = 1'b0;
        send(32'h84007FFF);
        send(32'h87384002);
        in_valid = 1'b1;
        in_instr = 32'h03048D15;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush_no_stale", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stream discards buffered packets
        out_ready = 1'b0;
        send(32'h00000000);
        send(32'h84007FFF);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        check("arst_outputs", 64'(obs_pkt()), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        send(32'hC2207FFC);
        wait_drain("final_drained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/operand_source_decoder.md
OPERAND_SOURCE_DECODER -- requirements
Module: operand_source_decoder

Interface
REQ-001 clk  in  1  single rising-edge clock; all state SHALL be clocked by it.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 in_valid  in  1  fetch stage presents instr.
REQ-004 in_instr  in  32  SPARC V8 instruction word.
REQ-005 in_ready  out  1  decoder accepts in_instr this cycle.
REQ-006 flush  in  1  synchronous pipeline kill.
REQ-007 out_valid  out  1  decoded operand packet valid.
REQ-008 out_ready  in  1  operand2 handler stage accepts packet.
REQ-009 out_is  out  4  operand-select code driven to the operand2 handler IS input.
REQ-010 out_imm  out  22  immediate driven to the operand2 handler Imm input.
REQ-011 out_rs1, out_rs2, out_rd  out  5 each  register-file addresses.
REQ-012 out_illegal  out  1  unsupported encoding flag.

Function
REQ-013 Decode SHALL be: op=00,op2=100 (SETHI) -> is=0000, imm=instr[21:0].
REQ-014 op=00,op2=010 (Bicc) -> is=0100, imm=instr[21:0].
REQ-015 op=01 (CALL) -> is=0110, imm=instr[21:0]; upper disp30 bits are dropped.
REQ-016 op=10, op3 in {100101,100110,100111} (SLL/SRL/SRA) -> is={101,i}.
REQ-017 op=10, op3=111000 (JMPL) -> is={111,i}.
REQ-018 op=10, any other op3 -> is={100,i}.
REQ-019 op=11 (load/store) -> is={110,i}.
REQ-020 All format-3 imm SHALL be {9{instr[12]}, instr[12:0]}, so imm[21] carries the simm13 sign.
REQ-021 op=00 with op2 not in {100,010} -> is=0000, imm=0, out_illegal=1; the packet is still delivered.
REQ-022 rs1=instr[18:14], rs2=instr[4:0], rd=instr[29:25] for every format; format 2 rs1/rs2 SHALL be 0.
REQ-023 Latency SHALL be exactly 1 cycle from accepted input to out_valid when the output register is empty or draining.
REQ-024 Handshake: transfer occurs on valid&&ready; out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 A 2-entry skid buffer SHALL decouple in_ready from out_ready; in_ready SHALL be a registered signal, equal to 1 iff fewer than 2 entries are occupied.
REQ-026 Occupancy states: EMPTY, ONE, FULL.
REQ-027 EMPTY->ONE on accept.
REQ-028 ONE->FULL on accept without drain; ONE->EMPTY on drain without accept; ONE stays ONE on simultaneous accept and drain.
REQ-029 FULL->ONE on drain; no accept is possible in FULL.
REQ-030 Order SHALL be strictly FIFO; no packet SHALL be dropped or duplicated.
REQ-031 flush SHALL empty both entries in the same cycle and drop any same-cycle input; out_valid=0 next cycle; in_ready=1 next cycle; flush overrides accept and drain.

Reset
REQ-032 On rst_n low, asynchronously: state=EMPTY, out_valid=0, in_ready=0, out_is=0000, out_imm=0, out_rs1/rs2/rd=0, out_illegal=0.
REQ-033 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-034 Reset mid-transfer SHALL discard all buffered packets.

Structure
REQ-035 A shared package operand_pkg SHALL hold the IS code constants (SETHI, BRANCH, CALL, ALU_R/I, SHIFT_R/I, MEM_R/I, JMPL_R/I), the op/op2/op3 field constants and the decoded-packet struct.
REQ-036 The combinational field decode SHALL be one function in operand_pkg.
REQ-037 The buffer SHALL be one sub-module, decode_skid_buffer, parameterized by packet width.

Verification
REQ-038 SETHI %hi(0x12345400),%g1 (0x03048D15) -> is=0000, imm=0x048D15, rd=1, 1-cycle latency.
REQ-039 add %g1,-1,%g2 (0x84007FFF) -> is=1001, imm=0x3FFFFF, rs1=1, rd=2; sra %g1,%g2,%g3 (0x87384002) -> is=1010, rs2=2.
REQ-040 Hold out_ready=0 while issuing 3 instructions -> the first 2 are accepted, in_ready=0, out_* stable; then out_ready=1 -> all 3 emerge in order with no gaps beyond 1 cycle.
REQ-041 Simultaneous accept and drain in state ONE for 10 cycles -> occupancy stays ONE; 10 packets are delivered in order.
REQ-042 Assert flush with the buffer FULL and in_valid=1 -> next cycle out_valid=0, in_ready=1, no stale packet later emerges.
REQ-043 op=00,op2=000 (UNIMP) -> out_illegal=1, is=0000, imm=0; rst_n pulsed mid-stream asynchronously -> all outputs 0 before the next edge.
